// File: rtl/mdu_ctrl.sv
// ---------------------------------------------------------------------------
// mdu_ctrl -- multiply/divide sequencer sitting behind the E stage.
//
// Takes the StartMDU / MoveToMDU / MoveFromMDU / MDUSel controls from the E
// pipeline register. It runs a multi-cycle MULT/MULTU/DIV/DIVU against the
// HI/LO pair. It raises stall_req so the hazard unit can freeze D and flush E
// while a D-stage MDU instruction would otherwise collide with a busy unit.
//
// The 64-bit result is computed and latched when the operation is launched.
// The busy period only models the unit's latency. The latched value is
// committed to {hi,lo} on the last busy cycle.
//
// Optional feature: define MDU_MADD_EN to enable MADD (sel=1x0) and
// MADDU (sel=1x1). These accumulate a*b into {hi,lo}. Without the macro,
// sel[2]=1 decodes as MULT/MULTU, selected by sel[0].
//
// Parameters
//   MUL_CYCLES  busy cycles for MULT/MULTU (and MADD/MADDU), >= 1
//   DIV_CYCLES  busy cycles for DIV/DIVU, >= 1
//
// Ports
//   clk        clock
//   rst        synchronous reset, active-high
//   start      launch the operation selected by sel
//   move_to    write a into HI (sel[0]=0) or LO (sel[0]=1)
//   move_from  E-stage read of HI/LO (rdata is steered by sel[0] alone)
//   sel        3-bit operation / register select
//   a, b       forwarded rs / rt operands
//   d_uses_mdu D-stage instruction is an MDU op
//   busy       operation in flight
//   stall_req  d_uses_mdu & (busy | start), combinational
//   hi, lo     HI / LO registers
//   rdata      sel[0] ? lo : hi, combinational
// ---------------------------------------------------------------------------
module mdu_ctrl #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        move_to,
  input  logic        move_from,
  input  logic [2:0]  sel,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_uses_mdu,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rdata
);

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic [63:0]      res_q;   // result latched at launch, committed at the end
  logic             skip_q;  // divide by zero: commit leaves HI/LO alone

  logic [63:0]      res_d;
  logic             skip_d;
  logic             is_div;

  // 32x32 -> 64 product. The operands are widened to 64 bits (sign- or
  // zero-extended), and the low 64 bits of that product are exactly the
  // signed or unsigned 64-bit result.
  function automatic logic [63:0] mul64(input logic [31:0] x,
                                        input logic [31:0] y,
                                        input logic        sgn);
    logic [63:0] xe;
    logic [63:0] ye;
    xe = {{32{sgn & x[31]}}, x};
    ye = {{32{sgn & y[31]}}, y};
    return xe * ye;
  endfunction

  // Returns {remainder, quotient}. The signed form divides magnitudes and
  // then fixes the signs. As a result, the quotient truncates toward zero
  // and the remainder takes the sign of the dividend.
  // For 0x80000000 / -1, the magnitude 0x80000000 / 1 wraps back to
  // quotient 0x80000000 with remainder 0.
  function automatic logic [63:0] div64(input logic [31:0] x,
                                        input logic [31:0] y,
                                        input logic        sgn);
    logic        neg_q;
    logic        neg_r;
    logic [31:0] xm;
    logic [31:0] ym;
    logic [31:0] q;
    logic [31:0] r;
    neg_r = sgn & x[31];
    neg_q = sgn & (x[31] ^ y[31]);
    xm    = neg_r ? -x : x;
    ym    = (sgn & y[31]) ? -y : y;
    q     = xm / ym;
    r     = xm % ym;
    if (neg_q) q = -q;
    if (neg_r) r = -r;
    return {r, q};
  endfunction

  // Launch decode: the result for the op currently presented on sel/a/b.
  always_comb begin
    is_div = 1'b0;
    skip_d = 1'b0;
    res_d  = '0;
    if (!sel[2] && sel[1]) begin
      is_div = 1'b1;
      if (b == 32'd0) begin
        skip_d = 1'b1;
      end else begin
        res_d = div64(a, b, ~sel[0]);
      end
    end else begin
`ifdef MDU_MADD_EN
      // The accumulator base is the {hi,lo} seen at launch.
      if (sel[2]) begin
        res_d = {hi_q, lo_q} + mul64(a, b, ~sel[0]);
      end else begin
        res_d = mul64(a, b, ~sel[0]);
      end
`else
      res_d = mul64(a, b, ~sel[0]);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      res_q   <= '0;
      skip_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // start takes priority over a simultaneous move_to.
          if (start) begin
            res_q   <= res_d;
            skip_q  <= skip_d;
            cnt_q   <= is_div ? DIV_LD : MUL_LD;
            state_q <= BUSY;
          end else if (move_to) begin
            if (sel[0]) begin
              lo_q <= a;
            end else begin
              hi_q <= a;
            end
          end
        end
        BUSY: begin
          // start/move_to are not looked at here; the stall keeps them away.
          if (cnt_q == CNT_ONE) begin
            if (!skip_q) begin
              {hi_q, lo_q} <= res_q;
            end
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = (state_q == BUSY);
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign stall_req = d_uses_mdu & (busy | start);
  assign rdata     = sel[0] ? lo_q : hi_q;

  // A read has no side effect, so move_from is not needed by any logic.
  logic unused_move_from;
  assign unused_move_from = move_from;

endmodule

// File: tb/tb_mdu_ctrl.sv
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        move_to;
  logic        move_from;
  logic [2:0]  sel;
  logic [31:0] a;
  logic [31:0] b;
  logic        d_uses_mdu;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rdata;

  mdu_ctrl #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .move_to    (move_to),
    .move_from  (move_from),
    .sel        (sel),
    .a          (a),
    .b          (b),
    .d_uses_mdu (d_uses_mdu),
    .busy       (busy),
    .stall_req  (stall_req),
    .hi         (hi),
    .lo         (lo),
    .rdata      (rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Launch one op and wait (bounded) for it to finish. The expected result
  // goes to the scoreboard; the monitor checks it when busy falls.
  task automatic do_op(input logic [2:0] s, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] eh, input logic [31:0] el, input int n,
                       input logic dum, input logic chk_st, input logic mt);
    exp_t e;
    int   k;
    e.hi = eh; e.lo = el; e.cyc = n;
    sb.push_back(e);
    sel = s; a = av; b = bv; start = 1'b1; move_to = mt; d_uses_mdu = dum;
    #1;
    if (chk_st) chk("stall_start_cycle", {31'd0, stall_req}, {31'd0, dum});
    @(negedge clk);
    #1;
    start = 1'b0; move_to = 1'b0;
    k = 0;
    while (busy && k < 64) begin
      if (chk_st) chk("stall_busy_cycle", {31'd0, stall_req}, {31'd0, dum});
      @(negedge clk);
      k++;
    end
    if (k >= 64) chk("op_timeout_busy", {31'd0, busy}, 32'd0);
    #1;
    if (chk_st) chk("stall_after_busy", {31'd0, stall_req}, 32'd0);
    d_uses_mdu = 1'b0;
  endtask

  task automatic do_move(input logic [2:0] s, input logic [31:0] av);
    sel = s; a = av; move_to = 1'b1;
    @(negedge clk);
    #1;
    move_to = 1'b0;
  endtask

  // Monitor: a falling busy is a commit unless reset caused it.
  initial begin : monitor
    logic prev_busy;
    int   busy_cnt;
    exp_t e;
    prev_busy = 1'b0;
    busy_cnt  = 0;
    forever begin
      @(negedge clk);
      if (busy === 1'b1) begin
        busy_cnt++;
      end else if (prev_busy) begin
        if (rst) begin
          busy_cnt = 0;
        end else if (sb.size() == 0) begin
          total++;
          $display("FAIL unexpected_commit: hi=0x%08h lo=0x%08h, no op outstanding", hi, lo);
          busy_cnt = 0;
        end else begin
          e = sb.pop_front();
          chk("commit_hi", hi, e.hi);
          chk("commit_lo", lo, e.lo);
          chk("busy_cycles", 32'(busy_cnt), 32'(e.cyc));
          busy_cnt = 0;
        end
      end
      prev_busy = (busy === 1'b1);
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst = 1'b1; start = 1'b0; move_to = 1'b0; move_from = 1'b0;
    sel = 3'b000; a = '0; b = '0; d_uses_mdu = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_stall", {31'd0, stall_req}, 32'd0);
    #1;
    rst = 1'b0; d_uses_mdu = 1'b0;
    @(negedge clk);
    #1;

    // MULT with D-stage MDU use every cycle: stall for start + 5 busy cycles.
    do_op(3'b000, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5, 1'b1, 1'b1, 1'b0);
    // MULTU, no D-stage MDU use: stall_req stays low.
    do_op(3'b001, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 5, 1'b0, 1'b1, 1'b0);
    // DIV -7/2 = -3 rem -1.
    do_op(3'b010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 1'b0, 1'b0, 1'b0);
    // DIVU 7/0 keeps prior HI/LO.
    do_op(3'b011, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 1'b0, 1'b0, 1'b0);
    // DIV overflow case.
    do_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10, 1'b0, 1'b0, 1'b0);
    // DIV 7/-2 = -3 rem 1 (remainder follows dividend).
    do_op(3'b010, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10, 1'b0, 1'b0, 1'b0);
    // DIVU 100/7 = 14 rem 2.
    do_op(3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 10, 1'b0, 1'b0, 1'b0);
    // MULT -3 * -4 = 12.
    do_op(3'b000, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 32'd0, 32'd12, 5, 1'b0, 1'b0, 1'b0);

    // Moves to HI then LO, each leaving the other register alone.
    do_move(3'b000, 32'h0000_ABCD);
    chk("move_to_hi", hi, 32'h0000_ABCD);
    chk("move_to_hi_lo_kept", lo, 32'd12);
    do_move(3'b001, 32'h0000_1234);
    chk("move_to_lo", lo, 32'h0000_1234);
    chk("move_to_lo_hi_kept", hi, 32'h0000_ABCD);
    move_from = 1'b1; sel = 3'b001;
    #1;
    chk("move_from_lo", rdata, 32'h0000_1234);
    sel = 3'b000;
    #1;
    chk("move_from_hi", rdata, 32'h0000_ABCD);
    move_from = 1'b0;
    @(negedge clk);
    #1;

    // start and move_to together: start wins (MULTU 3*5).
    do_op(3'b001, 32'd3, 32'd5, 32'd0, 32'd15, 5, 1'b0, 1'b0, 1'b1);

    // Reset during busy cycle 3 of a DIV: no commit, HI/LO cleared.
    sel = 3'b011; a = 32'd100; b = 32'd7; start = 1'b1;
    @(negedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_hi", hi, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);
    #1;
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("rst_no_commit_hi", hi, 32'd0);
    chk("rst_no_commit_lo", lo, 32'd0);
    chk("rst_stays_idle", {31'd0, busy}, 32'd0);
    #1;

    // sel[2]=1 ops: MADD/MADDU when enabled, otherwise MULT/MULTU.
    do_move(3'b001, 32'd5);
    chk("preload_lo", lo, 32'd5);
`ifdef MDU_MADD_EN
    do_op(3'b100, 32'd3, 32'd4, 32'd0, 32'd17, 5, 1'b0, 1'b0, 1'b0);
    do_op(3'b111, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'h0000_000F, 5, 1'b0, 1'b0, 1'b0);
    do_op(3'b110, 32'hFFFF_FFFF, 32'd1, 32'd2, 32'h0000_000E, 5, 1'b0, 1'b0, 1'b0);
`else
    do_op(3'b100, 32'd3, 32'd4, 32'd0, 32'd12, 5, 1'b0, 1'b0, 1'b0);
    do_op(3'b111, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE, 5, 1'b0, 1'b0, 1'b0);
    do_op(3'b110, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 1'b0, 1'b0, 1'b0);
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
